alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational `alu` instance between two requesters: requester 0 is the execute stage and requester 1 is the auxiliary address/CSR unit. Each requester uses a valid/ready handshake. The block selects one request per cycle with round-robin priority, drives the ALU's `alu_op`/`alu_in_0`/`alu_in_1`, and captures `alu_out` into a single-entry response register tagged with the requester ID. It sits between the issue logic and the ALU and is the only driver of the ALU's input ports.

## Interface
- `GPR_WIDTH`, default `DATA_WIDTH_GPR` (32): operand/result width.
- `OP_WIDTH`, default `DATA_WIDTH_ALU_OP`: ALU opcode width; encodings are the `ALU_OP_*` macros in define.v.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` input 1: request present.
- `req0_op`, `req1_op` input OP_WIDTH: requested ALU operation.
- `req0_in_0`, `req0_in_1`, `req1_in_0`, `req1_in_1` input GPR_WIDTH: operands.
- `req0_ready`, `req1_ready` output 1: request accepted this cycle.
- `alu_op` output OP_WIDTH: to ALU.
- `alu_in_0`, `alu_in_1` output GPR_WIDTH: to ALU.
- `alu_out` input GPR_WIDTH: from ALU (combinational result).
- `rsp_valid` output 1: response register holds a result.
- `rsp_id` output 1: requester that issued the held result.
- `rsp_data` output GPR_WIDTH: held result.
- `rsp_ready` input 1: consumer takes the response this cycle.

## Operation
- **Slot free:** `slot_free = ~rsp_valid | rsp_ready`.
- **Grant:**
  - One valid request: it is granted.
  - Both valid: the requester not equal to `last_grant` is granted.
  - None valid: no grant.
- **Handshake:** `reqN_ready = grant==N & reqN_valid & slot_free`. At most one ready per cycle. An accept happens when `reqN_valid & reqN_ready`.
- **ALU drive:**
  - When a grant exists, the ALU ports carry the granted requester's op/operands, whether or not `slot_free` holds.
  - With no grant, `alu_op`, `alu_in_0` and `alu_in_1` are all 0.
- **On accept at an edge:**
  - `rsp_data <= alu_out`, `rsp_id <= N`, `rsp_valid <= 1`, `last_grant <= N`.
- **Drain with no accept:** `rsp_valid & rsp_ready` with no accept gives `rsp_valid <= 0`. `rsp_data` and `rsp_id` keep their old values.
- **Stall:** `rsp_valid & ~rsp_ready` holds `rsp_data` and `rsp_id` stable and deasserts both readys. `last_grant` does not change.
- **Simultaneous drain and accept:** the response register is overwritten with the new result and `rsp_valid` stays 1. The old response is taken by the consumer in the same cycle.
- **Requester obligations:**
  - Once `reqN_valid` is high, op and operands stay stable until accepted.
  - Valid is not withdrawn before acceptance.
  - The block does not check these rules.
- **`last_grant` scope:** it changes only on an accept, never on an un-accepted grant.
- **Arithmetic:** none in this block; all results come from the ALU unmodified.

## Timing
- **Reset values (asynchronous):** `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `last_grant=1`, so requester 0 wins the first tie.
- **Combinational outputs:** `req*_ready` and the ALU ports follow inputs within the cycle.
- **Latency:** a request accepted in cycle N has its result on `rsp_data` with `rsp_valid=1` in cycle N+1.
- **Throughput:** one result per cycle while `rsp_ready=1`.
- **Back-pressure:** readys are 0 while `rsp_valid=1` and `rsp_ready=0`.
- **Contention:** two requesters valid continuously with `rsp_ready=1` are granted strictly alternately: 0,1,0,1…
- **Reset mid-operation:**
  - A held response is discarded and `rsp_valid` drops immediately on `rst` assertion.
  - Pending requests are not accepted while `rst=1`; readys are 0 during reset.
  - The first cycle after release behaves as after power-up.

## Test plan
- **Single request:** reset, then `req0_valid=1`, `ALU_OP_ADD`, in_0=5, in_1=7, `rsp_ready=1`. Expect `req0_ready=1` in that cycle; next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_data=12`.
- **Tie after reset, then alternation:** both valid after reset. req0 = `ALU_OP_SUB` 10−3; req1 = `ALU_OP_XOR` 0xF0F0^0x0FF0. Expect req0 granted first (`rsp_data=7`, id 0). Next cycle req1 is granted (`rsp_data=0xFF00`, id 1), then req0 again with both still valid.
- **Back-pressure:** drive `rsp_ready=0` with a response held and req1 valid. Expect both readys 0 and `rsp_data`/`rsp_id` unchanged for 3 cycles. On `rsp_ready=1`, req1 is accepted the same cycle and its result appears the next cycle.
- **Back-to-back streaming:** req0 valid for 4 consecutive cycles with ADD operands (1,1),(2,2),(3,3),(4,4) and `rsp_ready=1`. Expect 4 consecutive responses 2, 4, 6, 8 with no bubble.
- **Reset mid-operation:** assert `rst` asynchronously while `rsp_valid=1`, `rsp_data=12`. Expect `rsp_valid=0` and `rsp_data=0` immediately, and readys 0 during reset. After release with both requesters valid, req0 is granted first.
- **Idle:** no requests valid. Expect `alu_op=0`, `alu_in_0=0`, `alu_in_1=0`, both readys 0, and `rsp_valid` cleared after a pending response is drained.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between the execute stage (0)
// and the auxiliary address/CSR unit (1), capturing each result in a one-entry tagged response register.
module alu_arbiter #(
  parameter int GPR_WIDTH = 32,
  parameter int OP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  input  logic                 req1_valid,
  input  logic [OP_WIDTH-1:0]  req0_op,
  input  logic [OP_WIDTH-1:0]  req1_op,
  input  logic [GPR_WIDTH-1:0] req0_in_0,
  input  logic [GPR_WIDTH-1:0] req0_in_1,
  input  logic [GPR_WIDTH-1:0] req1_in_0,
  input  logic [GPR_WIDTH-1:0] req1_in_1,
  output logic                 req0_ready,
  output logic                 req1_ready,
  output logic [OP_WIDTH-1:0]  alu_op,
  output logic [GPR_WIDTH-1:0] alu_in_0,
  output logic [GPR_WIDTH-1:0] alu_in_1,
  input  logic [GPR_WIDTH-1:0] alu_out,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [GPR_WIDTH-1:0] rsp_data,
  input  logic                 rsp_ready
);

  // Handshake: a request transfers on a rising edge where reqN_valid & reqN_ready.
  // Ready is combinational and never depends on the requester's own ready, only on
  // its valid, the round-robin grant and whether the response slot can take a result.

  logic                 r_last_grant;
  logic                 r_rsp_valid;
  logic                 r_rsp_id;
  logic [GPR_WIDTH-1:0] r_rsp_data;

  logic w_slot_free;
  logic w_grant_valid;
  logic w_grant_id;
  logic w_accept;

  assign w_slot_free   = ~r_rsp_valid | rsp_ready;
  assign w_grant_valid = req0_valid | req1_valid;
  // On a tie the requester that did not win last time goes; otherwise the lone requester.
  assign w_grant_id    = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;

  // Readys are masked by rst so nothing is taken while reset is held.
  assign req0_ready = ~rst & w_slot_free & req0_valid & ~w_grant_id;
  assign req1_ready = ~rst & w_slot_free & req1_valid &  w_grant_id;
  assign w_accept   = req0_ready | req1_ready;

  always_comb begin
    alu_op   = '0;
    alu_in_0 = '0;
    alu_in_1 = '0;
    if (w_grant_valid) begin
      if (w_grant_id) begin
        alu_op   = req1_op;
        alu_in_0 = req1_in_0;
        alu_in_1 = req1_in_1;
      end else begin
        alu_op   = req0_op;
        alu_in_0 = req0_in_0;
        alu_in_1 = req0_in_1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant_id;
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_grant_id;
      r_rsp_data   <= alu_out;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by constrained-random
// traffic, all checked against a transaction-level model and a response scoreboard.
module tb_alu_arbiter;

  localparam int GW = 32;
  localparam int OW = 4;

  localparam logic [OW-1:0] ALU_OP_ADD = 4'd1;
  localparam logic [OW-1:0] ALU_OP_SUB = 4'd2;
  localparam logic [OW-1:0] ALU_OP_AND = 4'd3;
  localparam logic [OW-1:0] ALU_OP_OR  = 4'd4;
  localparam logic [OW-1:0] ALU_OP_XOR = 4'd5;

  logic          clk, rst;
  logic          req0_valid, req1_valid;
  logic [OW-1:0] req0_op, req1_op;
  logic [GW-1:0] req0_in_0, req0_in_1, req1_in_0, req1_in_1;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] alu_op;
  logic [GW-1:0] alu_in_0, alu_in_1, alu_out;
  logic          rsp_valid, rsp_id;
  logic [GW-1:0] rsp_data;
  logic          rsp_ready;

  alu_arbiter #(.GPR_WIDTH(GW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_in_0(req0_in_0), .req0_in_1(req0_in_1),
    .req1_in_0(req1_in_0), .req1_in_1(req1_in_1),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [GW-1:0] ref_alu(input logic [OW-1:0] op,
                                            input logic [GW-1:0] a, input logic [GW-1:0] b);
    case (op)
      ALU_OP_ADD: return a + b;
      ALU_OP_SUB: return a - b;
      ALU_OP_AND: return a & b;
      ALU_OP_OR:  return a | b;
      ALU_OP_XOR: return a ^ b;
      default:    return '0;
    endcase
  endfunction

  // The external combinational ALU the block drives.
  assign alu_out = ref_alu(alu_op, alu_in_0, alu_in_1);

  // ---------------- model + scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  int            m_last;
  bit            m_valid;
  int            m_id;
  logic [GW-1:0] m_data;
  logic [GW-1:0] exp_q[$];
  bit            acc0, acc1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_valid = 0;
    m_id    = 0;
    m_data  = '0;
    exp_q.delete();
  endtask

  // One clock of traffic: combinational outputs checked at the falling edge,
  // registered outputs 1 time unit after the rising edge.
  task automatic cycle();
    int            g;
    bit            free_slot;
    logic [OW-1:0] e_op;
    logic [GW-1:0] e_a, e_b, res;
    @(negedge clk);
    free_slot = !m_valid || rsp_ready;
    if (req0_valid && req1_valid) g = 1 - m_last;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    e_op = (g == 0) ? req0_op   : (g == 1) ? req1_op   : '0;
    e_a  = (g == 0) ? req0_in_0 : (g == 1) ? req1_in_0 : '0;
    e_b  = (g == 0) ? req0_in_1 : (g == 1) ? req1_in_1 : '0;
    check("req0_ready", 64'(req0_ready), 64'((g == 0) && free_slot));
    check("req1_ready", 64'(req1_ready), 64'((g == 1) && free_slot));
    check("alu_op",     64'(alu_op),     64'(e_op));
    check("alu_in_0",   64'(alu_in_0),   64'(e_a));
    check("alu_in_1",   64'(alu_in_1),   64'(e_b));
    if (m_valid && rsp_ready) begin
      check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) check("sb_consumed", 64'(rsp_data), 64'(exp_q.pop_front()));
    end
    acc0 = (g == 0) && free_slot;
    acc1 = (g == 1) && free_slot;
    if (acc0 || acc1) begin
      res = ref_alu(e_op, e_a, e_b);
      m_data  = res;
      m_id    = g;
      m_valid = 1;
      m_last  = g;
      exp_q.push_back(res);
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    check("rsp_id",    64'(rsp_id),    64'(m_id));
    check("rsp_data",  64'(rsp_data),  64'(m_data));
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req0(input bit v, input logic [OW-1:0] op,
                            input logic [GW-1:0] a, input logic [GW-1:0] b);
    req0_valid = v; req0_op = op; req0_in_0 = a; req0_in_1 = b;
  endtask

  task automatic drive_req1(input bit v, input logic [OW-1:0] op,
                            input logic [GW-1:0] a, input logic [GW-1:0] b);
    req1_valid = v; req1_op = op; req1_in_0 = a; req1_in_1 = b;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  logic [GW-1:0] held_data;
  logic          held_id;

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    drive_req0(0, '0, '0, '0);
    drive_req1(0, '0, '0, '0);
    model_reset();
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    check("reset_rsp_id",    64'(rsp_id),    64'(0));
    check("reset_rsp_data",  64'(rsp_data),  64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request
    rsp_ready = 1'b1;
    drive_req0(1, ALU_OP_ADD, 5, 7);
    cycle();
    check("single_accept", 64'(acc0), 64'(1));
    check("single_data",   64'(rsp_data), 64'(12));
    check("single_id",     64'(rsp_id),   64'(0));

    // Tie after reset, then alternation
    pulse_reset();
    drive_req0(1, ALU_OP_SUB, 10, 3);
    drive_req1(1, ALU_OP_XOR, 32'hF0F0, 32'h0FF0);
    cycle();
    check("tie_first_data", 64'(rsp_data), 64'(7));
    check("tie_first_id",   64'(rsp_id),   64'(0));
    cycle();
    check("alt_second_data", 64'(rsp_data), 64'(32'hFF00));
    check("alt_second_id",   64'(rsp_id),   64'(1));
    cycle();
    check("alt_third_id",    64'(rsp_id),   64'(0));

    // Back-pressure with a held response and req1 waiting
    drive_req0(0, '0, '0, '0);
    rsp_ready = 1'b0;
    held_data = rsp_data;
    held_id   = rsp_id;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_no_accept", 64'(acc1), 64'(0));
      check("bp_data_hold", 64'(rsp_data), 64'(held_data));
      check("bp_id_hold",   64'(rsp_id),   64'(held_id));
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_release_accept", 64'(acc1), 64'(1));
    check("bp_release_data",   64'(rsp_data), 64'(32'hFF00));
    drive_req1(0, '0, '0, '0);

    // Back-to-back streaming
    for (int i = 1; i <= 4; i++) begin
      drive_req0(1, ALU_OP_ADD, GW'(i), GW'(i));
      cycle();
      check("stream_valid", 64'(rsp_valid), 64'(1));
      check("stream_data",  64'(rsp_data),  64'(2 * i));
    end

    // Reset mid-operation
    drive_req0(1, ALU_OP_ADD, 5, 7);
    cycle();
    check("pre_rst_data", 64'(rsp_data), 64'(12));
    drive_req1(1, ALU_OP_OR, 32'h0F, 32'hF0);
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_async_valid", 64'(rsp_valid), 64'(0));
    check("rst_async_data",  64'(rsp_data),  64'(0));
    check("rst_ready0",      64'(req0_ready), 64'(0));
    check("rst_ready1",      64'(req1_ready), 64'(0));
    @(posedge clk);
    #1;
    check("rst_hold_valid",  64'(rsp_valid), 64'(0));
    rst = 1'b0;
    cycle();
    check("post_rst_first_id", 64'(rsp_id), 64'(0));
    check("post_rst_accept0",  64'(acc0),   64'(1));

    // Idle with pending response drained
    drive_req0(0, '0, '0, '0);
    drive_req1(0, '0, '0, '0);
    cycle();
    check("idle_drained", 64'(rsp_valid), 64'(0));
    cycle();

    // Constrained-random traffic honouring the hold-until-accepted rule
    acc0 = 1; acc1 = 1;
    for (int n = 0; n < 400; n++) begin
      if (!req0_valid || acc0)
        drive_req0($urandom_range(0, 3) != 0, OW'($urandom_range(1, 5)), $urandom, $urandom);
      if (!req1_valid || acc1)
        drive_req1($urandom_range(0, 3) != 0, OW'($urandom_range(1, 5)), $urandom, $urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
